// File: rtl/chimera_clu_pwr_seq.sv
// ============================================================================
//  Module   : chimera_clu_pwr_seq
//  Purpose  : Round-robin, one-at-a-time clock/reset/isolation sequencer for
//             the Chimera compute clusters. Optional CHIMERA_CLU_PWR_SEQ_IRQ_EN
//             adds a completion pulse and the ID of the completed cluster.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module chimera_clu_pwr_seq #(
    parameter int unsigned NUM_CLUSTERS      = 5,
    parameter int unsigned CLK_SETTLE_CYCLES = 4,
    parameter int unsigned RST_SETTLE_CYCLES = 8,
    parameter int unsigned ISO_CYCLES        = 2,
    localparam int unsigned SEL_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1
) (
    input  logic                    soc_clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CLUSTERS-1:0] en_req_i,
    output logic [NUM_CLUSTERS-1:0] clu_clk_en_o,
    output logic [NUM_CLUSTERS-1:0] clu_rst_no,
    output logic [NUM_CLUSTERS-1:0] clu_iso_o,
    output logic [NUM_CLUSTERS-1:0] clu_on_o,
    output logic                    busy_o,
    output logic [SEL_W-1:0]        sel_o
`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
    ,
    output logic                    done_irq_o,
    output logic [SEL_W-1:0]        done_id_o
`endif
);

    localparam int unsigned MAX_A    = (CLK_SETTLE_CYCLES > RST_SETTLE_CYCLES) ?
                                       CLK_SETTLE_CYCLES : RST_SETTLE_CYCLES;
    localparam int unsigned MAX_WAIT = (MAX_A > ISO_CYCLES) ? MAX_A : ISO_CYCLES;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    // Counter loads N-1 so each state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] C_CLK_LOAD = CNT_W'(CLK_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_RST_LOAD = CNT_W'(RST_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ISO_LOAD = CNT_W'(ISO_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UP_CLK = 3'd1,
        ST_UP_RST = 3'd2,
        ST_UP_ISO = 3'd3,
        ST_DN_ISO = 3'd4,
        ST_DN_RST = 3'd5,
        ST_DN_CLK = 3'd6
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [SEL_W-1:0]        ptr_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    busy_q;
    logic [NUM_CLUSTERS-1:0] clk_en_q;
    logic [NUM_CLUSTERS-1:0] rst_n_q;
    logic [NUM_CLUSTERS-1:0] iso_q;
    logic [NUM_CLUSTERS-1:0] on_q;
`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
    logic                    done_irq_q;
    logic [SEL_W-1:0]        done_id_q;
`endif

    logic [NUM_CLUSTERS-1:0] pending_d;
    logic                    pick_vld_d;
    logic [SEL_W-1:0]        pick_idx_d;
    logic [SEL_W-1:0]        cand_d;
    logic [SEL_W-1:0]        ptr_d;

    assign pending_d = en_req_i ^ on_q;
    assign ptr_d     = (sel_q == SEL_W'(NUM_CLUSTERS - 1)) ? '0 : sel_q + 1'b1;

    // First pending cluster at or after the round-robin pointer, with wrap.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        cand_d     = '0;
        for (int off = 0; off < int'(NUM_CLUSTERS); off++) begin
            cand_d = SEL_W'((int'(ptr_q) + off) % int'(NUM_CLUSTERS));
            if (!pick_vld_d && pending_d[cand_d]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand_d;
            end
        end
    end

    always_ff @(posedge soc_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            clk_en_q   <= '0;
            rst_n_q    <= '0;
            iso_q      <= '1;
            on_q       <= '0;
`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
            done_irq_q <= 1'b0;
            done_id_q  <= '0;
`endif
        end else begin
`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
            done_irq_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_d) begin
                        sel_q  <= pick_idx_d;
                        busy_q <= 1'b1;
                        if (on_q[pick_idx_d]) begin
                            state_q            <= ST_DN_ISO;
                            iso_q[pick_idx_d]  <= 1'b1;
                            on_q[pick_idx_d]   <= 1'b0;
                            cnt_q              <= C_ISO_LOAD;
                        end else begin
                            state_q              <= ST_UP_CLK;
                            clk_en_q[pick_idx_d] <= 1'b1;
                            cnt_q                <= C_CLK_LOAD;
                        end
                    end
                end
                ST_UP_CLK: begin
                    if (cnt_q == '0) begin
                        state_q        <= ST_UP_RST;
                        rst_n_q[sel_q] <= 1'b1;
                        cnt_q          <= C_RST_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_UP_RST: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_UP_ISO;
                        iso_q[sel_q] <= 1'b0;
                        on_q[sel_q]  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DN_ISO: begin
                    if (cnt_q == '0) begin
                        state_q        <= ST_DN_RST;
                        rst_n_q[sel_q] <= 1'b0;
                        cnt_q          <= C_RST_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DN_RST: begin
                    if (cnt_q == '0) begin
                        state_q         <= ST_DN_CLK;
                        clk_en_q[sel_q] <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_UP_ISO, ST_DN_CLK: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    ptr_q      <= ptr_d;
`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
                    done_irq_q <= 1'b1;
                    done_id_q  <= sel_q;
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clu_clk_en_o = clk_en_q;
    assign clu_rst_no   = rst_n_q;
    assign clu_iso_o    = iso_q;
    assign clu_on_o     = on_q;
    assign busy_o       = busy_q;
    assign sel_o        = sel_q;
`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
    assign done_irq_o   = done_irq_q;
    assign done_id_o    = done_id_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_chimera_clu_pwr_seq.sv
// Directed bench for chimera_clu_pwr_seq (default parameters: 5 clusters, 4/8/2 cycles).
`default_nettype none

module tb_chimera_clu_pwr_seq;

    logic       clk;
    logic       rst_n;
    logic [4:0] en_req;
    logic [4:0] clk_en;
    logic [4:0] rst_no;
    logic [4:0] iso;
    logic [4:0] on;
    logic       busy;
    logic [2:0] sel;
`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
    logic       done_irq;
    logic [2:0] done_id;
`endif

    int vectors;
    int miscompares;

    chimera_clu_pwr_seq dut (
        .soc_clk_i    (clk),
        .rst_ni       (rst_n),
        .en_req_i     (en_req),
        .clu_clk_en_o (clk_en),
        .clu_rst_no   (rst_no),
        .clu_iso_o    (iso),
        .clu_on_o     (on),
        .busy_o       (busy),
        .sel_o        (sel)
`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
        ,
        .done_irq_o   (done_irq),
        .done_id_o    (done_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released mid-cycle; the next edge is cycle 1.
    task automatic do_reset(input logic [4:0] req);
        rst_n  = 1'b0;
        en_req = req;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        en_req = 5'b00000;
        repeat (3) tick();
        vectors++; if (clk_en !== 5'b00000) begin miscompares++; $display("FAIL rst_clk_en got=%b exp=00000", clk_en); end
        vectors++; if (rst_no !== 5'b00000) begin miscompares++; $display("FAIL rst_rst_n got=%b exp=00000", rst_no); end
        vectors++; if (iso !== 5'b11111) begin miscompares++; $display("FAIL rst_iso got=%b exp=11111", iso); end
        vectors++; if (on !== 5'b00000) begin miscompares++; $display("FAIL rst_on got=%b exp=00000", on); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
        vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL rst_sel got=%0d exp=0", sel); end
    endtask

    task automatic test_power_up();
        logic [4:0] e_rst, e_iso, e_on;
        logic       e_busy;
        do_reset(5'b00001);
        for (int c = 1; c <= 16; c++) begin
            tick();
            e_rst  = (c >= 5)  ? 5'b00001 : 5'b00000;
            e_iso  = (c >= 13) ? 5'b11110 : 5'b11111;
            e_on   = (c >= 13) ? 5'b00001 : 5'b00000;
            e_busy = (c <= 13);
            vectors++; if (clk_en !== 5'b00001) begin miscompares++; $display("FAIL pu_clk_en c=%0d got=%b exp=00001", c, clk_en); end
            vectors++; if (rst_no !== e_rst) begin miscompares++; $display("FAIL pu_rst_n c=%0d got=%b exp=%b", c, rst_no, e_rst); end
            vectors++; if (iso !== e_iso) begin miscompares++; $display("FAIL pu_iso c=%0d got=%b exp=%b", c, iso, e_iso); end
            vectors++; if (on !== e_on) begin miscompares++; $display("FAIL pu_on c=%0d got=%b exp=%b", c, on, e_on); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL pu_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
            vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL pu_sel c=%0d got=%0d exp=0", c, sel); end
        end
    endtask

    // Sequence k occupies cycles 14k+1..14k+13, idle at 14k+14.
    task automatic test_round_robin();
        logic [4:0] e_on;
        do_reset(5'b11111);
        for (int c = 1; c <= 70; c++) begin
            tick();
            for (int k = 0; k < 5; k++) begin
                e_on = 5'((1 << (k + 1)) - 1);
                if (c == 14 * k + 1) begin
                    vectors++; if (sel !== 3'(k)) begin miscompares++; $display("FAIL rr_sel c=%0d got=%0d exp=%0d", c, sel, k); end
                    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rr_busy_start c=%0d got=%b exp=1", c, busy); end
                    vectors++; if (clk_en !== e_on) begin miscompares++; $display("FAIL rr_clk_en c=%0d got=%b exp=%b", c, clk_en, e_on); end
                end
                if (c == 14 * k + 13) begin
                    vectors++; if (on !== e_on) begin miscompares++; $display("FAIL rr_on c=%0d got=%b exp=%b", c, on, e_on); end
                end
                if (c == 14 * k + 14) begin
                    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_idle c=%0d got=%b exp=0", c, busy); end
                end
            end
            if (c == 68) begin
                vectors++; if (on !== 5'b01111) begin miscompares++; $display("FAIL rr_on68 got=%b exp=01111", on); end
            end
        end
        vectors++; if (iso !== 5'b00000) begin miscompares++; $display("FAIL rr_iso_final got=%b exp=00000", iso); end
        vectors++; if (rst_no !== 5'b11111) begin miscompares++; $display("FAIL rr_rst_final got=%b exp=11111", rst_no); end
    endtask

    // Continues from all clusters on, RR pointer back at 0.
    task automatic test_power_down();
        logic [4:0] e_rst, e_clk;
        logic       e_busy;
        en_req = 5'b11110;
        for (int c = 1; c <= 13; c++) begin
            tick();
            e_rst  = (c >= 3)  ? 5'b11110 : 5'b11111;
            e_clk  = (c >= 11) ? 5'b11110 : 5'b11111;
            e_busy = (c <= 11);
            vectors++; if (iso !== 5'b00001) begin miscompares++; $display("FAIL pd_iso c=%0d got=%b exp=00001", c, iso); end
            vectors++; if (on !== 5'b11110) begin miscompares++; $display("FAIL pd_on c=%0d got=%b exp=11110", c, on); end
            vectors++; if (rst_no !== e_rst) begin miscompares++; $display("FAIL pd_rst_n c=%0d got=%b exp=%b", c, rst_no, e_rst); end
            vectors++; if (clk_en !== e_clk) begin miscompares++; $display("FAIL pd_clk_en c=%0d got=%b exp=%b", c, clk_en, e_clk); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL pd_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
        end
    endtask

    // Up: cycles 1..13, idle 14, down: 15..25, idle 26.
    task automatic test_reversal();
        do_reset(5'b00100);
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 6) en_req = 5'b00000;
            if (c == 13) begin
                vectors++; if (on !== 5'b00100) begin miscompares++; $display("FAIL rev_on_up got=%b exp=00100", on); end
                vectors++; if (iso !== 5'b11011) begin miscompares++; $display("FAIL rev_iso_up got=%b exp=11011", iso); end
            end
            if (c == 14) begin
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rev_idle got=%b exp=0", busy); end
            end
            if (c == 15) begin
                vectors++; if (on !== 5'b00000) begin miscompares++; $display("FAIL rev_on_dn got=%b exp=00000", on); end
                vectors++; if (sel !== 3'd2) begin miscompares++; $display("FAIL rev_sel got=%0d exp=2", sel); end
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rev_busy_dn got=%b exp=1", busy); end
            end
            if (c == 25) begin
                vectors++; if (clk_en !== 5'b00000) begin miscompares++; $display("FAIL rev_clk_dn got=%b exp=00000", clk_en); end
            end
        end
        vectors++; if (on !== 5'b00000) begin miscompares++; $display("FAIL rev_on_final got=%b exp=00000", on); end
        vectors++; if (clk_en !== 5'b00000) begin miscompares++; $display("FAIL rev_clk_final got=%b exp=00000", clk_en); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rev_busy_final got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        do_reset(5'b01000);
        repeat (14) tick();
        vectors++; if (on !== 5'b01000) begin miscompares++; $display("FAIL ar_on_up got=%b exp=01000", on); end
        en_req = 5'b00000;
        repeat (5) tick();
        vectors++; if (rst_no !== 5'b00000) begin miscompares++; $display("FAIL ar_in_dnrst got=%b exp=00000", rst_no); end
        vectors++; if (clk_en !== 5'b01000) begin miscompares++; $display("FAIL ar_clk_pre got=%b exp=01000", clk_en); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (clk_en !== 5'b00000) begin miscompares++; $display("FAIL ar_clk_en got=%b exp=00000", clk_en); end
        vectors++; if (iso !== 5'b11111) begin miscompares++; $display("FAIL ar_iso got=%b exp=11111", iso); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ar_busy got=%b exp=0", busy); end
        vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL ar_sel got=%0d exp=0", sel); end
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            vectors++; if (busy !== 1'b0 || clk_en !== 5'b00000 || iso !== 5'b11111) begin
                miscompares++; $display("FAIL ar_quiet c=%0d got busy=%b clk=%b iso=%b exp busy=0 clk=00000 iso=11111", c, busy, clk_en, iso);
            end
        end
    endtask

`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
    task automatic test_irq();
        logic       e_irq;
        logic [2:0] e_id;
        do_reset(5'b10000);
        vectors++; if (done_id !== 3'd0) begin miscompares++; $display("FAIL irq_id_rst got=%0d exp=0", done_id); end
        for (int c = 1; c <= 18; c++) begin
            tick();
            e_irq = (c == 14);
            e_id  = (c >= 14) ? 3'd4 : 3'd0;
            vectors++; if (done_irq !== e_irq) begin miscompares++; $display("FAIL irq_pulse c=%0d got=%b exp=%b", c, done_irq, e_irq); end
            vectors++; if (done_id !== e_id) begin miscompares++; $display("FAIL irq_id c=%0d got=%0d exp=%0d", c, done_id, e_id); end
        end
        vectors++; if (on !== 5'b10000) begin miscompares++; $display("FAIL irq_on got=%b exp=10000", on); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        en_req      = 5'b00000;
        test_reset();
        test_power_up();
        test_round_robin();
        test_power_down();
        test_reversal();
        test_async_reset();
`ifdef CHIMERA_CLU_PWR_SEQ_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/chimera_clu_pwr_seq.md
Name: chimera_clu_pwr_seq

Overview:
- Sequences clock enable, reset and isolation for the Chimera compute clusters, one cluster at a time, to bound inrush current and reset skew.
- Sits in the SoC domain between the cluster-control register file and the per-cluster clock gates, reset generators and isolation cells on the clu_clk boundary.
- Software writes a desired on/off level per cluster. A round-robin arbiter picks one mismatching cluster, and an FSM runs its power-up or power-down sequence.

Parameters:
- NumClusters, 5, number of sequenced clusters (≥1).
- ClkSettleCycles, 4, cycles between clock enable and reset release on power-up (≥1).
- RstSettleCycles, 8, cycles between reset release and isolation release on power-up, and between reset assertion and clock disable on power-down (≥1).
- IsoCycles, 2, cycles between isolation assertion and reset assertion on power-down (≥1).

Ports:
- soc_clk_i  in  1  SoC clock; the only clock of the block.
- rst_ni  in  1  asynchronous active-low reset.
- en_req_i  in  NumClusters  desired cluster state, level (1=on).
- clu_clk_en_o  out  NumClusters  cluster clock-gate enable.
- clu_rst_no  out  NumClusters  cluster reset, active-low.
- clu_iso_o  out  NumClusters  output isolation enable, active-high.
- clu_on_o  out  NumClusters  status: cluster fully on.
- busy_o  out  1  a sequence is in progress.
- sel_o  out  $clog2(NumClusters) (min 1)  index of the cluster being sequenced.

Behaviour:
- Interface: one clock, soc_clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: clu_clk_en_o=0, clu_rst_no=0, clu_iso_o=all 1, clu_on_o=0, busy_o=0, sel_o=0, RR pointer=0, FSM=IDLE.
- All outputs are registered.
- A cluster is pending when en_req_i[i] != clu_on_o[i].
- Arbiter: in IDLE, scan from the RR pointer upward with wrap and pick the first pending cluster k.
  - Next cycle: sel_o=k, busy_o=1, FSM enters the first state of the up or down sequence.
  - The RR pointer becomes k+1 (mod NumClusters) when the sequence completes.
- Wait counter: one shared down-counter, width $clog2(max parameter+1), loaded on state entry.
- Power-up sequence (clu_on_o[k]=0, en_req_i[k]=1):
  - UP_CLK: clu_clk_en_o[k]=1; hold ClkSettleCycles.
  - UP_RST: clu_rst_no[k]=1; hold RstSettleCycles.
  - UP_ISO: clu_iso_o[k]=0 and clu_on_o[k]=1 in the same cycle; return to IDLE and drop busy_o.
  - Timing: clk_en rises 1 cycle after the request is seen in IDLE. rst_n rises ClkSettleCycles later. iso falls RstSettleCycles after that.
- Power-down sequence (clu_on_o[k]=1, en_req_i[k]=0):
  - DN_ISO: clu_iso_o[k]=1 and clu_on_o[k]=0; hold IsoCycles.
  - DN_RST: clu_rst_no[k]=0; hold RstSettleCycles.
  - DN_CLK: clu_clk_en_o[k]=0; return to IDLE.
- Transitions between sequences: IDLE lasts at least 1 cycle. With several clusters pending, sequences run back-to-back with one IDLE cycle between them.
- Request change mid-sequence: the running sequence completes unchanged. On return to IDLE the cluster is re-evaluated and the reverse sequence is then selected by RR.
- Request pulses shorter than a sequence are not tracked; only the level seen in IDLE matters.
- Non-selected clusters' outputs never change.
- Reset asserted mid-sequence: all outputs return to reset values asynchronously. No sequence resumes after reset.
- Invariants on all outputs:
  - clu_rst_no[i]=1 implies clu_clk_en_o[i]=1.
  - clu_iso_o[i]=0 implies clu_rst_no[i]=1.

Optional Feature:
- Macro: CHIMERA_CLU_PWR_SEQ_IRQ_EN.
- When defined, the block adds output done_irq_o (1 bit), a single-cycle pulse in the cycle after a sequence returns to IDLE.
- It also adds done_id_o ($clog2(NumClusters) bits), holding the completed cluster index until the next completion (reset 0).
- When undefined, neither port exists, and the remaining behaviour is identical.

Test Plan:
- Power-up, defaults: en_req_i=5'b00001 after reset.
  - clk_en[0] rises at cycle 1, rst_no[0] at cycle 5, iso[0] falls and on[0] rises at cycle 13.
  - busy_o is high over cycles 1–13.
- Power-down: from all on, en_req_i=5'b11110.
  - iso[0]=1 and on[0]=0 at cycle 1, rst_no[0]=0 at cycle 3, clk_en[0]=0 at cycle 11.
  - Other clusters do not toggle.
- Round-robin: en_req_i=5'b11111 from reset.
  - Clusters power up in order 0,1,2,3,4, with sel_o following.
  - Exactly one IDLE cycle between sequences; all clu_on_o=1 after 5×13+4 cycles.
- Mid-sequence reversal: en_req_i[2]=1, then 0 during UP_RST.
  - Power-up completes (on[2]=1), then the down sequence runs. Final state is on[2]=0, clk_en[2]=0.
- Async reset: assert rst_ni during DN_RST of cluster 3.
  - All outputs go to reset values with no clock edge. busy_o=0.
  - After release with en_req_i=0, no activity occurs.
- IRQ (macro defined): full power-up of cluster 4.
  - done_irq_o pulses high for 1 cycle after on[4] rises; done_id_o=4 and holds.
